segment_transition_ctl: RTL
===========================

Name: segment_transition_ctl

Overview:
Parametrised successor to the fixed two-segment modulation/STM segment swap. Owns the sample index and active segment for one playback engine (MOD or STM) across NUM_SEGMENT segments. Applies segment changes under the SYNC_IDX, SYS_TIME, GPIO, EXT and new IMMEDIATE transition modes, and enforces finite or infinite repeat counts. Sits between the controller register file and the mod/STM sample readers; index advance is paced by an external freq-div tick.

Parameters:
NUM_SEGMENT, 4, number of segments (>=2); SEG_W = $clog2(NUM_SEGMENT)
IDX_WIDTH, 15, sample index width
REP_WIDTH, 16, repeat counter width; all-ones = infinite
NUM_GPIO, 4, GPIO trigger inputs; GPIO_W = $clog2(NUM_GPIO)

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
TICK  in  1  one-cycle strobe, one per sample period
UPDATE_SETTINGS  in  1  one-cycle pulse, latches a transition request
REQ_SEGMENT  in  SEG_W  requested segment
TRANSITION_MODE  in  8  transition_mode_t
TRANSITION_VALUE  in  64  SYS_TIME target, or GPIO select in [GPIO_W-1:0]
CYCLE  in  NUM_SEGMENT*IDX_WIDTH  per-segment last index
REP  in  NUM_SEGMENT*REP_WIDTH  per-segment repeats minus one
SYS_TIME  in  64  global system time
GPIO_IN  in  NUM_GPIO  asynchronous trigger pins
SEGMENT  out  SEG_W  active segment
IDX  out  IDX_WIDTH  current sample index
STOP  out  1  finite repeat exhausted
BUSY  out  1  request pending
REQ_ERR  out  1  one-cycle pulse, request rejected
LAST_TRANSITION_TIME  out  64  see Optional Feature

Behaviour:
- Reset (async assert, sync release): SEGMENT=0, IDX=0, STOP=0, BUSY=0, REQ_ERR=0, loop count=0, state RUN, pending cleared, LAST_TRANSITION_TIME=0.
- States: RUN, PENDING, STOPPED.
- Index advance (RUN/PENDING):
  - on TICK: IDX<CYCLE[SEGMENT] -> IDX+1.
  - Else wrap to 0 and loop+1.
  - When REP[SEGMENT] != all-ones and loop reaches REP+1: hold IDX=CYCLE[SEGMENT], STOP=1, go STOPPED. In EXT mode, instead advance segment per EXT rule.
- UPDATE_SETTINGS accepted in any state:
  - Latches segment/mode/value; BUSY=1; go PENDING.
  - Newer request overwrites a pending one (latest wins).
  - REQ_SEGMENT>=NUM_SEGMENT or unknown mode: ignored, REQ_ERR pulses next cycle, state unchanged.
- Trigger conditions (evaluated in PENDING):
  - SYNC_IDX: TICK at IDX==CYCLE[SEGMENT]. In STOPPED: next TICK.
  - SYS_TIME: SYS_TIME >= TRANSITION_VALUE (unsigned). A past value fires on the first PENDING cycle.
  - GPIO: rising edge of synchronised GPIO_IN[sel]. 2-flop sync plus edge register gives 3 cycles pin-to-trigger.
  - IMMEDIATE (8'hFF): fires the cycle after acceptance.
  - EXT: fires like SYNC_IDX. Thereafter, on repeat exhaustion, SEGMENT <= (SEGMENT+1) mod NUM_SEGMENT, IDX=0, loop=0, no STOP. Continues until a non-EXT request fires.
- Transition fires on cycle n -> at n+1: SEGMENT=new, IDX=0, loop=0, STOP=0, BUSY=0, state RUN. The firing TICK is consumed by the swap, not an extra increment.
- Request to the currently active segment is legal: restarts the loop count at the trigger.
- UPDATE_SETTINGS coincident with a trigger: the trigger fires with the old request; the new request then becomes pending.
- CYCLE/REP changes for the active segment take effect at the next comparison; IDX>CYCLE is treated as a wrap.

Optional Feature:
- Macro SEGMENT_TRANSITION_TIMESTAMP_EN.
- Defined: LAST_TRANSITION_TIME registers SYS_TIME on every fired transition, including EXT auto-advance.
- Undefined: LAST_TRANSITION_TIME constant 0 and no capture register synthesised.

Decomposition:
- Shared package: transition_mode_t extended with TRANSITION_MODE_IMMEDIATE=8'hFF; REP_INFINITE localparam; seg_ctl_state_t enum {RUN, PENDING, STOPPED}.
- Sub-module gpio_trigger_sync: NUM_GPIO 2-flop synchronisers plus rising-edge pulse generation.

Test Plan:
- NUM_SEGMENT=4, CYCLE[0]=3, REP[0]=all-ones, TICK every cycle -> IDX 0,1,2,3,0,…; STOP stays 0.
- REP[0]=1, CYCLE[0]=3 -> 8 ticks, then IDX holds 3, STOP=1. SYNC_IDX request to seg 2 -> next TICK gives SEGMENT=2, IDX=0, STOP=0.
- SYS_TIME mode, value 1000, SYS_TIME ramping -> swap on the cycle after SYS_TIME==1000. BUSY 1 until then, 0 after.
- GPIO mode, sel=2, GPIO_IN[2] rises at cycle t -> SEGMENT updates at t+4. GPIO_IN[1] edges are ignored.
- EXT from seg 0, REP=0 for all, CYCLE=1 -> SEGMENT sequence 0,1,2,3,0 every 2 ticks. REQ_SEGMENT=5 -> REQ_ERR pulse, no change.
- Assert RST_N mid-PENDING -> all outputs 0 immediately. IMMEDIATE request after release -> swap 1 cycle later.

Source files
------------

// File: rtl/segment_transition_ctl_pkg.sv
// Shared types for the segment transition controller.
// Transition modes, controller states and the infinite-repeat marker.
package segment_transition_ctl_pkg;

  typedef enum logic [7:0] {
    TRANSITION_MODE_SYNC_IDX  = 8'h00,
    TRANSITION_MODE_SYS_TIME  = 8'h01,
    TRANSITION_MODE_GPIO      = 8'h02,
    TRANSITION_MODE_EXT       = 8'hF0,
    TRANSITION_MODE_IMMEDIATE = 8'hFF
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN,
    PENDING,
    STOPPED
  } seg_ctl_state_t;

  localparam logic [63:0] REP_INFINITE = '1;

  typedef struct packed {
    transition_mode_t mode;
    logic [63:0]      value;
  } transition_req_t;

  function automatic logic mode_known(input logic [7:0] m);
    case (m)
      TRANSITION_MODE_SYNC_IDX,
      TRANSITION_MODE_SYS_TIME,
      TRANSITION_MODE_GPIO,
      TRANSITION_MODE_EXT,
      TRANSITION_MODE_IMMEDIATE: mode_known = 1'b1;
      default:                   mode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/segment_transition_ctl_gpio_trigger_sync.sv
// GPIO trigger synchroniser: two-flop sync per pin plus a
// registered rising-edge pulse (pin to pulse = 3 cycles).
module gpio_trigger_sync #(
  parameter int NUM_GPIO = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_GPIO-1:0] GPIO_IN,
  output logic [NUM_GPIO-1:0] RISE
);

  logic [NUM_GPIO-1:0] meta_q;
  logic [NUM_GPIO-1:0] sync_q;
  logic [NUM_GPIO-1:0] prev_q;
  logic [NUM_GPIO-1:0] rise_q;

  // Synchronise the pins and register one-cycle rising-edge pulses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
    end else begin
      meta_q <= GPIO_IN;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign RISE = rise_q;

endmodule

// File: rtl/segment_transition_ctl.sv
// Segment/index controller for one playback engine.
// SEGMENT_TRANSITION_TIMESTAMP_EN adds the transition timestamp.
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter int NUM_SEGMENT = 4,
  parameter int IDX_WIDTH   = 15,
  parameter int REP_WIDTH   = 16,
  parameter int NUM_GPIO    = 4,
  localparam int SEG_W  = (NUM_SEGMENT > 1) ? $clog2(NUM_SEGMENT) : 1,
  localparam int GPIO_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           TICK,
  input  logic                           UPDATE_SETTINGS,
  input  logic [SEG_W-1:0]               REQ_SEGMENT,
  input  logic [7:0]                     TRANSITION_MODE,
  input  logic [63:0]                    TRANSITION_VALUE,
  input  logic [NUM_SEGMENT*IDX_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENT*REP_WIDTH-1:0] REP,
  input  logic [63:0]                    SYS_TIME,
  input  logic [NUM_GPIO-1:0]            GPIO_IN,
  output logic [SEG_W-1:0]               SEGMENT,
  output logic [IDX_WIDTH-1:0]           IDX,
  output logic                           STOP,
  output logic                           BUSY,
  output logic                           REQ_ERR,
  output logic [63:0]                    LAST_TRANSITION_TIME
);

  seg_ctl_state_t       state_q, state_d;
  logic [SEG_W-1:0]     seg_q, seg_d;
  logic [SEG_W-1:0]     pseg_q, pseg_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d, cyc;
  logic [REP_WIDTH-1:0] loop_q, loop_d, rep;
  logic                 stop_q, stop_d;
  logic                 ext_q, ext_d;
  logic                 err_q, err_d;
  transition_req_t      preq_q, preq_d;
  logic [NUM_GPIO-1:0]  rise;
  logic [GPIO_W-1:0]    gsel;
  logic                 at_end, exhaust;
  logic                 trig, fire, req_ok;

  gpio_trigger_sync #(
    .NUM_GPIO(NUM_GPIO)
  ) u_gpio (
    .CLK,
    .RST_N,
    .GPIO_IN,
    .RISE(rise)
  );

  assign cyc  = CYCLE[int'(seg_q)*IDX_WIDTH +: IDX_WIDTH];
  assign rep  = REP[int'(seg_q)*REP_WIDTH +: REP_WIDTH];
  assign gsel = preq_q.value[GPIO_W-1:0];

  // An index past CYCLE (after a CYCLE shrink) counts as the end
  assign at_end  = idx_q >= cyc;
  assign exhaust = at_end
                && (rep != REP_INFINITE[REP_WIDTH-1:0])
                && (loop_q >= rep);
  assign req_ok  = UPDATE_SETTINGS
                && mode_known(TRANSITION_MODE)
                && (int'(REQ_SEGMENT) < NUM_SEGMENT);

  // Trigger condition of the pending request
  always_comb begin
    trig = 1'b0;
    case (preq_q.mode)
      TRANSITION_MODE_SYNC_IDX,
      TRANSITION_MODE_EXT:       trig = TICK && (stop_q || at_end);
      TRANSITION_MODE_SYS_TIME:  trig = SYS_TIME >= preq_q.value;
      TRANSITION_MODE_GPIO:      trig = rise[gsel];
      TRANSITION_MODE_IMMEDIATE: trig = 1'b1;
      default:                   trig = 1'b0;
    endcase
  end

  assign fire = (state_q == PENDING) && trig;

  // Next state: swap, index advance, then request capture
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    stop_d  = stop_q;
    ext_d   = ext_q;
    pseg_d  = pseg_q;
    preq_d  = preq_q;
    err_d   = UPDATE_SETTINGS && !req_ok;
    if (fire) begin
      seg_d   = pseg_q;
      idx_d   = '0;
      loop_d  = '0;
      stop_d  = 1'b0;
      ext_d   = (preq_q.mode == TRANSITION_MODE_EXT);
      state_d = RUN;
    end else if (TICK && !stop_q) begin
      if (!at_end) begin
        idx_d = idx_q + 1'b1;
      end else if (!exhaust) begin
        idx_d  = '0;
        loop_d = loop_q + 1'b1;
      end else if (ext_q) begin
        seg_d  = (seg_q == SEG_W'(NUM_SEGMENT - 1))
               ? '0 : seg_q + 1'b1;
        idx_d  = '0;
        loop_d = '0;
      end else begin
        idx_d  = cyc;
        stop_d = 1'b1;
        if (state_q != PENDING) state_d = STOPPED;
      end
    end
    if (req_ok) begin
      pseg_d       = REQ_SEGMENT;
      preq_d.mode  = transition_mode_t'(TRANSITION_MODE);
      preq_d.value = TRANSITION_VALUE;
      state_d      = PENDING;
    end
  end

  // Controller state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      seg_q   <= '0;
      idx_q   <= '0;
      loop_q  <= '0;
      stop_q  <= 1'b0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
      pseg_q  <= '0;
      preq_q  <= '{mode: TRANSITION_MODE_SYNC_IDX, value: '0};
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
      pseg_q  <= pseg_d;
      preq_q  <= preq_d;
    end
  end

`ifdef SEGMENT_TRANSITION_TIMESTAMP_EN
  logic        stamp;
  logic [63:0] ts_q;

  assign stamp = fire || (TICK && !stop_q && exhaust && ext_q);

  // Capture system time on every segment change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     ts_q <= '0;
    else if (stamp) ts_q <= SYS_TIME;
  end

  assign LAST_TRANSITION_TIME = ts_q;
`else
  assign LAST_TRANSITION_TIME = '0;
`endif

  assign SEGMENT = seg_q;
  assign IDX     = idx_q;
  assign STOP    = stop_q;
  assign BUSY    = (state_q == PENDING);
  assign REQ_ERR = err_q;

endmodule
